uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one 8N1 UART transmitter among `N_REQ` byte-stream requesters, such as a debug console, an RX echo path and a status reporter. Each requester presents bytes with valid/ready/last handshakes. The arbiter grants the transmitter to one requester for a whole packet, sequences each byte through the transmitter's `tx_start`/`tx_busy` handshake, and caps every grant at `MAX_BURST` bytes so that no requester can starve the others. It sits between the requesters and `uart_tx`, in the same clock domain as `uart_rx`/`uart_tx` and the baud tick generator.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one 8N1 UART transmitter among N_REQ byte-stream requesters.
// A grant covers a whole packet (up to MAX_BURST bytes); owners rotate
// round-robin starting from the requester after the last owner.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   req_valid     per-requester byte valid
//   req_data      packed bytes, requester i on [8i+7:8i]
//   req_last      presented byte ends its packet
//   req_ready     combinational accept, only toward the owner while issuing
//   tx_start      registered one-clock start pulse to uart_tx
//   tx_data       byte for uart_tx, held until the next transfer
//   tx_busy       transmitter busy from uart_tx
//   grant_active  a requester owns the transmitter
//   grant_id      owner index, holds its last value while idle
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int IDW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t         state, state_d;
  logic [IDW-1:0] rr_ptr, rr_ptr_d;
  logic [IDW-1:0] grant_id_d;
  logic           grant_active_d;
  logic [7:0]     burst_cnt, burst_cnt_d;
  logic           last_q, last_q_d;
  logic           tx_start_d;
  logic [7:0]     tx_data_d;

  logic [IDW-1:0] pick_id;
  logic           pick_found;
  logic [N_REQ-1:0] owner_mask;
  logic           sel_valid;
  logic           sel_last;
  logic [7:0]     sel_data;
  logic [IDW-1:0] rr_next;

  // Owner-side mux of the request signals.
  always_comb begin
    owner_mask = '0;
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        owner_mask[i] = 1'b1;
        sel_valid     = req_valid[i];
        sel_last      = req_last[i];
        sel_data      = req_data[8*i +: 8];
      end
    end
  end

  // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned j;
    j          = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!pick_found && req_valid[j]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(j);
      end
    end
  end

  assign rr_next   = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign req_ready = (state == S_ISSUE) ? owner_mask : '0;

  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    grant_id_d     = grant_id;
    grant_active_d = grant_active;
    burst_cnt_d    = burst_cnt;
    last_q_d       = last_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data;
    unique case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_d     = pick_id;
          grant_active_d = 1'b1;
          burst_cnt_d    = '0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A stalled owner keeps the grant indefinitely.
        if (sel_valid) begin
          tx_data_d   = sel_data;
          tx_start_d  = 1'b1;
          last_q_d    = sel_last;
          burst_cnt_d = burst_cnt + 8'd1;
          state_d     = S_GUARD;
        end
      end
      S_GUARD: begin
        // tx_busy may not have risen yet; skip one clock before sampling it.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (last_q || (burst_cnt == 8'(MAX_BURST))) begin
            grant_active_d = 1'b0;
            rr_ptr_d       = rr_next;
            state_d        = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      burst_cnt    <= '0;
      last_q       <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      grant_id     <= grant_id_d;
      grant_active <= grant_active_d;
      burst_cnt    <= burst_cnt_d;
      last_q       <= last_q_d;
      tx_start     <= tx_start_d;
      tx_data      <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance 0 uses MAX_BURST=16, instance 1 uses
// MAX_BURST=2. Requesters are byte queues; expected transmit order comes
// from a packet-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NR-1:0]   req_valid [2];
  logic [8*NR-1:0] req_data  [2];
  logic [NR-1:0]   req_last  [2];
  logic [NR-1:0]   req_ready [2];
  logic            tx_start  [2];
  logic [7:0]      tx_data   [2];
  logic            tx_busy   [2];
  logic            grant_active [2];
  logic [1:0]      grant_id  [2];

  logic [8:0] rq [2][NR][$];   // {last, data}
  logic [9:0] obs_q [2][$];    // {owner, data}
  int         obs_cyc [2][$];
  logic [9:0] exp_q [2][$];
  int         rr_m [2];
  logic [NR-1:0] stall [2];
  bit         rand_busy = 1'b0;
  int         busy_len = 20;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(NR), .MAX_BURST(16), .IDW(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_last(req_last[0]),
    .req_ready(req_ready[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .tx_busy(tx_busy[0]), .grant_active(grant_active[0]), .grant_id(grant_id[0])
  );

  uart_tx_arbiter #(.N_REQ(NR), .MAX_BURST(2), .IDW(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_last(req_last[1]),
    .req_ready(req_ready[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .tx_busy(tx_busy[1]), .grant_active(grant_active[1]), .grant_id(grant_id[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Requesters: present queue front, pop on a handshake seen mid-cycle.
  initial begin : drv
    logic [NR-1:0] fire [2];
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_data[d] = '0; req_last[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) fire[d] = req_valid[d] & req_ready[d];
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NR; i++) begin
          if (fire[d][i] && rq[d][i].size() > 0) void'(rq[d][i].pop_front());
          if (rq[d][i].size() > 0 && !stall[d][i]) begin
            req_valid[d][i]        = 1'b1;
            req_data[d][8*i +: 8]  = rq[d][i][0][7:0];
            req_last[d][i]         = rq[d][i][0][8];
          end else begin
            req_valid[d][i] = 1'b0;
            req_last[d][i]  = 1'b0;
          end
        end
      end
    end
  end

  // uart_tx model plus transmit monitor.
  initial begin : mon
    int   bcnt [2];
    int   last_len [2];
    logic prev_start [2];
    for (int d = 0; d < 2; d++) begin
      bcnt[d] = 0; last_len[d] = 0; prev_start[d] = 1'b0; tx_busy[d] = 1'b0;
    end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (bcnt[d] > 0) begin
          bcnt[d]--;
          if (bcnt[d] == 0) tx_busy[d] = 1'b0;
        end
        if (tx_start[d] === 1'b1) begin
          chk("tx_start_width", prev_start[d], 1'b0);
          chk("start_while_granted", grant_active[d], 1'b1);
          if (obs_cyc[d].size() > 0)
            chk("tx_gap", (cyc - obs_cyc[d][$]) >= last_len[d] + 2, 1'b1);
          obs_q[d].push_back({grant_id[d], tx_data[d]});
          obs_cyc[d].push_back(cyc);
          last_len[d] = rand_busy ? int'($urandom_range(1, 25)) : busy_len;
          bcnt[d]     = last_len[d];
          tx_busy[d]  = 1'b1;
        end
        prev_start[d] = tx_start[d];
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic push_byte(input int d, input int r, input logic [7:0] b, input logic last);
    rq[d][r].push_back({last, b});
  endtask

  task automatic push_pkt(input int d, input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(d, r, 8'($urandom), k == len - 1);
  endtask

  // Packet-level round robin over everything currently queued.
  task automatic model_run(input int d);
    int p [NR];
    int left, o, cnt, mb, j;
    bit found;
    logic [8:0] e;
    mb = (d == 0) ? 16 : 2;
    left = 0;
    for (int i = 0; i < NR; i++) begin
      p[i] = 0;
      left += rq[d][i].size();
    end
    while (left > 0) begin
      found = 1'b0;
      o = 0;
      for (int k = 0; k < NR; k++) begin
        j = (rr_m[d] + k) % NR;
        if (!found && p[j] < rq[d][j].size()) begin
          found = 1'b1;
          o = j;
        end
      end
      cnt = 0;
      do begin
        e = rq[d][o][p[o]];
        p[o]++; left--; cnt++;
        exp_q[d].push_back({2'(o), e[7:0]});
      end while (!e[8] && cnt < mb && p[o] < rq[d][o].size());
      rr_m[d] = (o + 1) % NR;
    end
  endtask

  function automatic bit all_empty(input int d);
    for (int i = 0; i < NR; i++) if (rq[d][i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (n < budget && !(all_empty(d) && !grant_active[d] && !tx_busy[d] &&
                           obs_q[d].size() >= exp_q[d].size())) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle_timeout", n < budget, 1'b1);
  endtask

  task automatic wait_obs(input int d, input int k, input int budget);
    int n = 0;
    while (n < budget && obs_q[d].size() < k) begin
      @(posedge clk); #2;
      n++;
    end
    chk("obs_timeout", obs_q[d].size() >= k, 1'b1);
  endtask

  task automatic check_seq(input int d, input string tag);
    chk({tag, "_count"}, obs_q[d].size(), exp_q[d].size());
    for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++)
      chk(tag, obs_q[d][i], exp_q[d][i]);
    obs_q[d].delete(); obs_cyc[d].delete(); exp_q[d].delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    rr_m[0] = 0; rr_m[1] = 0;
  endtask

  initial begin : main
    int c0, n;
    logic seen, ga_low, st_seen, oth_seen;
    int burst_owner [10];
    burst_owner = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1};
    stall[0] = '0; stall[1] = '0;
    rr_m[0] = 0; rr_m[1] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_tx_start", tx_start[d], 1'b0);
      chk("rst_tx_data", tx_data[d], 8'h00);
      chk("rst_grant_active", grant_active[d], 1'b0);
      chk("rst_grant_id", grant_id[d], 2'd0);
      chk("rst_req_ready", req_ready[d], 4'h0);
    end
    rst = 1'b0;
    @(posedge clk); #2;

    // Single requester, fixed 20-clk busy
    c0 = cyc;
    push_byte(0, 0, 8'h41, 1'b0);
    push_byte(0, 0, 8'h42, 1'b0);
    push_byte(0, 0, 8'h43, 1'b1);
    model_run(0);
    n = 0;
    while (!grant_active[0] && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    chk("grant_latency", cyc - c0, 2);
    wait_idle(0, 300);
    chk("single_starts", obs_cyc[0].size(), 3);
    if (obs_cyc[0].size() >= 3) begin
      chk("start_latency", obs_cyc[0][0] - c0, 3);
      chk("gap_1", obs_cyc[0][1] - obs_cyc[0][0], 22);
      chk("gap_2", obs_cyc[0][2] - obs_cyc[0][1], 22);
    end
    chk("single_release", grant_active[0], 1'b0);
    check_seq(0, "single");

    // rr_ptr now points at 1
    push_byte(0, 0, 8'h10, 1'b1);
    push_byte(0, 1, 8'h11, 1'b1);
    model_run(0);
    wait_idle(0, 200);
    check_seq(0, "rr_after_single");

    // Simultaneous 1-byte packets after reset
    pulse_reset();
    push_byte(0, 0, 8'hA0, 1'b1);
    push_byte(0, 0, 8'hB0, 1'b1);
    push_byte(0, 1, 8'hA1, 1'b1);
    push_byte(0, 2, 8'hA2, 1'b1);
    push_byte(0, 3, 8'hA3, 1'b1);
    model_run(0);
    wait_idle(0, 400);
    check_seq(0, "simultaneous");

    // Burst cap on the MAX_BURST=2 instance
    push_pkt(1, 0, 5);
    push_pkt(1, 1, 5);
    model_run(1);
    wait_idle(1, 600);
    chk("burst_count", obs_q[1].size(), 10);
    for (int i = 0; i < 10 && i < obs_q[1].size(); i++)
      chk("burst_owner", obs_q[1][i][9:8], 2'(burst_owner[i]));
    check_seq(1, "burst");

    // Packet atomicity: 1 and 3 arrive after requester 2's first byte
    push_pkt(0, 2, 4);
    model_run(0);
    wait_obs(0, 1, 50);
    push_byte(0, 1, 8'hE1, 1'b1);
    push_byte(0, 3, 8'hE3, 1'b1);
    exp_q[0].push_back({2'd3, 8'hE3});
    exp_q[0].push_back({2'd1, 8'hE1});
    rr_m[0] = 2;
    seen = 1'b0;
    n = 0;
    while (n < 300 && !(obs_q[0].size() >= 4 && !(grant_active[0] && grant_id[0] == 2'd2))) begin
      @(negedge clk);
      seen = seen | req_ready[0][1];
      n++;
    end
    chk("atomic_wait", n < 300, 1'b1);
    chk("atomic_no_ready1", seen, 1'b0);
    wait_idle(0, 400);
    check_seq(0, "atomic");

    // Requester 3 stalls mid-packet while requester 0 waits
    push_pkt(0, 3, 4);
    model_run(0);
    wait_obs(0, 1, 50);
    stall[0][3] = 1'b1;
    push_byte(0, 0, 8'h5A, 1'b1);
    exp_q[0].push_back({2'd0, 8'h5A});
    rr_m[0] = 1;
    @(posedge clk); #2;
    ga_low = 1'b0; st_seen = 1'b0; oth_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      ga_low   = ga_low | !grant_active[0];
      st_seen  = st_seen | tx_start[0];
      oth_seen = oth_seen | (|(req_ready[0] & 4'b0111));
    end
    chk("stall_grant_held", ga_low, 1'b0);
    chk("stall_no_start", st_seen, 1'b0);
    chk("stall_no_ready_others", oth_seen, 1'b0);
    @(posedge clk); #2;
    c0 = cyc;
    stall[0][3] = 1'b0;
    wait_obs(0, 2, 20);
    if (obs_cyc[0].size() >= 2) chk("stall_resume", obs_cyc[0][1] - c0, 2);
    wait_idle(0, 400);
    check_seq(0, "stall");

    // Reset during S_WAIT
    push_byte(0, 1, 8'hC7, 1'b0);
    push_byte(0, 1, 8'hC8, 1'b0);
    push_byte(0, 1, 8'hC9, 1'b1);
    wait_obs(0, 1, 50);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_tx_start", tx_start[0], 1'b0);
    chk("arst_tx_data", tx_data[0], 8'h00);
    chk("arst_grant_active", grant_active[0], 1'b0);
    chk("arst_grant_id", grant_id[0], 2'd0);
    chk("arst_req_ready", req_ready[0], 4'h0);
    for (int i = 0; i < NR; i++) rq[0][i].delete();
    obs_q[0].delete(); obs_cyc[0].delete(); exp_q[0].delete();
    @(posedge clk); #2;
    rst = 1'b0;
    rr_m[0] = 0; rr_m[1] = 0;
    n = 0;
    while (tx_busy[0] && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    chk("aborted_byte_done", tx_busy[0], 1'b0);
    push_byte(0, 3, 8'h73, 1'b1);
    push_byte(0, 0, 8'h70, 1'b1);
    model_run(0);
    wait_idle(0, 200);
    check_seq(0, "post_reset");

    // Randomized packets and busy times on both instances
    rand_busy = 1'b1;
    for (int round = 0; round < 6; round++) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < NR; r++) begin
          if ($urandom_range(0, 3) != 0) begin
            for (int p = 0; p < int'($urandom_range(1, 3)); p++)
              push_pkt(d, r, int'($urandom_range(1, 6)));
          end
        end
        model_run(d);
      end
      wait_idle(0, 5000);
      wait_idle(1, 5000);
      check_seq(0, "random_d0");
      check_seq(1, "random_d1");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
